// File: rtl/aer_pkg.sv
// Shared definitions for the AER output sink: the handshake FSM state
// encoding, default widths, and the helper that turns the configured ACK
// delay into a delay-counter load value.
package aer_pkg;

    // Default address and event-counter widths for aerout_sink.
    localparam int AER_WIDTH_DEF = 12;
    localparam int CNT_WIDTH_DEF = 16;

    // The delay counter covers ACK delays of 0..63 cycles.
    localparam int DLY_W = 6;

    // States of the 4-phase receive handshake.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        DELAY   = 3'd2,
        ACK_HI  = 3'd3,
        WAIT_LO = 3'd4
    } aer_state_t;

    // The counter is loaded on leaving CAPTURE and counts down to zero. It
    // therefore holds DELAY for `delay` cycles when loaded with delay-1. A
    // zero delay skips DELAY, so the load value is unused in that case.
    function automatic logic [DLY_W-1:0] dly_load(input int delay);
        logic [DLY_W-1:0] load;
        load = '0;
        if (delay > 0) begin
            load = DLY_W'(delay - 1);
        end
        return load;
    endfunction

endpackage

// File: rtl/aer_fifo.sv
// Synchronous FIFO that buffers captured AER addresses. The pointers carry
// one extra wrap bit, so FULL and EMPTY are exact and need no occupancy
// counter. The read data and the read-valid flag are registered. A pop that
// arrives while the FIFO is empty is ignored.
module aer_fifo
    import aer_pkg::*;
#(
    parameter int WIDTH = AER_WIDTH_DEF,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // The FIFO is empty when both pointers are equal, including the wrap
    // bit. It is full when the index bits match and the wrap bits differ.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees its slot in the same cycle. That lets a push into a full
    // FIFO proceed when it is paired with a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Pointer update. Each pointer wraps modulo 2*DEPTH through its extra bit.
    // NOTE: every sequential block uses non-blocking assignments. All flops
    // then sample the values from before the edge, whatever order the blocks
    // are evaluated in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write.
    // NOTE: the storage array has no reset. EMPTY guards every read, so no
    // stale entry can be observed, and leaving the reset off lets the array
    // map onto plain RAM.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Registered read port. Popped data appears the cycle after the pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/aerout_sink.sv
// Receiving end of a 4-phase AER link. Each request is captured into an
// address FIFO and counted. The acknowledge is raised after a configurable
// delay and held until the request drops. SAMPLE_DONE snapshots the event
// count and clears it.
// Build option: define AEROUT_SYNC_EN to pass AEROUT_REQ through a 2-flop
// synchronizer. This suits senders asynchronous to CLK and adds two cycles
// to the ACK rise and to the WAIT_LO exit.
module aerout_sink
    import aer_pkg::*;
#(
    parameter int AER_WIDTH  = AER_WIDTH_DEF,
    parameter int ACK_DELAY  = 6,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [AER_WIDTH-1:0] AEROUT_ADDR,
    input  logic                 AEROUT_REQ,
    output logic                 AEROUT_ACK,
    input  logic                 SAMPLE_DONE,
    input  logic                 RD_EN,
    output logic [AER_WIDTH-1:0] RD_ADDR,
    output logic                 RD_VALID,
    output logic                 FIFO_FULL,
    output logic                 FIFO_EMPTY,
    output logic [CNT_WIDTH-1:0] EVT_COUNT,
    output logic [CNT_WIDTH-1:0] EVT_COUNT_LAST
);

    localparam bit                   NO_DELAY = (ACK_DELAY == 0);
    localparam logic [DLY_W-1:0]     DLY_LOAD = dly_load(ACK_DELAY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    aer_state_t       state;
    logic [DLY_W-1:0] dly_cnt;
    logic             req_s;
    logic             capture;

`ifdef AEROUT_SYNC_EN
    logic [1:0] req_sync;

    // Two-flop synchronizer for a request from an asynchronous sender. It
    // resets to 0, so a request still high after reset is seen as new.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_sync <= 2'b00;
        end else begin
            req_sync <= {req_sync[0], AEROUT_REQ};
        end
    end

    assign req_s = req_sync[1];
`else
    // The sender is synchronous to CLK, so the request is sampled directly.
    assign req_s = AEROUT_REQ;
`endif

    // Exactly one capture happens per request phase, in the single CAPTURE
    // cycle.
    assign capture = (state == CAPTURE);

    // Handshake FSM with a registered acknowledge. ACK is set while leaving
    // ACK_HI and cleared on the same edge that returns WAIT_LO to IDLE.
    // IDLE holds off new requests while the FIFO is full.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            AEROUT_ACK <= 1'b0;
            dly_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_s && !FIFO_FULL) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (NO_DELAY) begin
                        state <= ACK_HI;
                    end else begin
                        dly_cnt <= DLY_LOAD;
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        state <= ACK_HI;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                ACK_HI: begin
                    AEROUT_ACK <= 1'b1;
                    state      <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!req_s) begin
                        AEROUT_ACK <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    AEROUT_ACK <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Saturating event counter. SAMPLE_DONE snapshots the count before any
    // increment from the same cycle, then restarts the count at 0, or at 1
    // when a capture coincides.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EVT_COUNT      <= '0;
            EVT_COUNT_LAST <= '0;
        end else if (SAMPLE_DONE) begin
            EVT_COUNT_LAST <= EVT_COUNT;
            EVT_COUNT      <= capture ? CNT_ONE : '0;
        end else if (capture && (EVT_COUNT != CNT_MAX)) begin
            EVT_COUNT <= EVT_COUNT + CNT_ONE;
        end
    end

    aer_fifo #(
        .WIDTH (AER_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (capture),
        .push_data (AEROUT_ADDR),
        .pop       (RD_EN),
        .rd_data   (RD_ADDR),
        .rd_valid  (RD_VALID),
        .full      (FIFO_FULL),
        .empty     (FIFO_EMPTY)
    );

endmodule

// File: tb/tb_aerout_sink.sv
// Directed bench for aerout_sink: reset state, single-event latency,
// back-pressure, ordering across pointer wrap, sample boundary, counter
// saturation and reset in the middle of a handshake.
module tb_aerout_sink;

    localparam int AW = 12;
    localparam int AD = 6;
    localparam int FD = 16;
    localparam int CW = 4;
`ifdef AEROUT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // The ACK rises 2 + ACK_DELAY cycles after the FSM sees REQ high.
    localparam int ACK_LAT = 2 + AD + SYNC_LAT;
    localparam int FALL_LAT = 1 + SYNC_LAT;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] AEROUT_ADDR = '0;
    logic          AEROUT_REQ = 1'b0;
    logic          AEROUT_ACK;
    logic          SAMPLE_DONE = 1'b0;
    logic          RD_EN = 1'b0;
    logic [AW-1:0] RD_ADDR;
    logic          RD_VALID;
    logic          FIFO_FULL;
    logic          FIFO_EMPTY;
    logic [CW-1:0] EVT_COUNT;
    logic [CW-1:0] EVT_COUNT_LAST;

    aerout_sink #(
        .AER_WIDTH  (AW),
        .ACK_DELAY  (AD),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .AEROUT_ADDR    (AEROUT_ADDR),
        .AEROUT_REQ     (AEROUT_REQ),
        .AEROUT_ACK     (AEROUT_ACK),
        .SAMPLE_DONE    (SAMPLE_DONE),
        .RD_EN          (RD_EN),
        .RD_ADDR        (RD_ADDR),
        .RD_VALID       (RD_VALID),
        .FIFO_FULL      (FIFO_FULL),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .EVT_COUNT      (EVT_COUNT),
        .EVT_COUNT_LAST (EVT_COUNT_LAST)
    );

    always #5 CLK = ~CLK;

    // Edge counter: read 1 ns after an edge, it holds that edge's number.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Collects every popped address; RD_VALID is a one-cycle registered flag.
    logic [AW-1:0] rd_q[$];
    always @(negedge CLK) begin
        if (RD_VALID === 1'b1) rd_q.push_back(RD_ADDR);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits, with a bound, for ACK to reach lvl. Returns the edge number,
    // or -1000 on timeout.
    task automatic wait_ack(input logic lvl, output int e);
        int n;
        n = 0;
        while (AEROUT_ACK !== lvl && n < 100) begin
            tick();
            n++;
        end
        e = (AEROUT_ACK === lvl) ? cyc : -1000;
    endtask

    // Runs one full 4-phase handshake. pop_cap / sd_cap pulse RD_EN /
    // SAMPLE_DONE during the CAPTURE cycle. Returns the ACK rise latency from
    // the REQ sampling edge, and the ACK fall delay from the REQ drop.
    task automatic do_event(input logic [AW-1:0] a, input bit pop_cap, input bit sd_cap,
                            output int lat, output int fall_gap);
        int t, r, f, d;
        AEROUT_ADDR = a;
        AEROUT_REQ  = 1'b1;
        t = cyc + 1;
        if (pop_cap || sd_cap) begin
            repeat (1 + SYNC_LAT) tick();
            RD_EN       = pop_cap;
            SAMPLE_DONE = sd_cap;
            tick();
            RD_EN       = 1'b0;
            SAMPLE_DONE = 1'b0;
        end
        wait_ack(1'b1, r);
        lat = r - t;
        AEROUT_REQ = 1'b0;
        d = cyc;
        wait_ack(1'b0, f);
        fall_gap = f - d;
    endtask

    task automatic pop_one(output logic [AW-1:0] a, output logic v);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        a = RD_ADDR;
        v = RD_VALID;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        int lat, gap, bad, r, f, p, e;
        logic [AW-1:0] a;
        logic v;

        // ---- reset state ----
        tick();
        tick();
        check("rst_ack", 32'(AEROUT_ACK), 0);
        check("rst_empty", 32'(FIFO_EMPTY), 1);
        check("rst_full", 32'(FIFO_FULL), 0);
        check("rst_rd_valid", 32'(RD_VALID), 0);
        check("rst_rd_addr", 32'(RD_ADDR), 0);
        check("rst_evt_count", 32'(EVT_COUNT), 0);
        check("rst_evt_last", 32'(EVT_COUNT_LAST), 0);
        RST = 1'b0;
        tick();

        // ---- single event ----
        do_event(12'h2A5, 1'b0, 1'b0, lat, gap);
        check("single_ack_latency", lat, ACK_LAT);
        check("single_ack_fall", gap, FALL_LAT);
        check("single_evt_count", 32'(EVT_COUNT), 1);
        check("single_not_empty", 32'(FIFO_EMPTY), 0);
        pop_one(a, v);
        check("single_rd_addr", 32'(a), 32'h2A5);
        check("single_rd_valid", 32'(v), 1);
        tick();
        check("single_valid_drops", 32'(RD_VALID), 0);
        check("single_empty_after", 32'(FIFO_EMPTY), 1);
        pop_one(a, v);
        check("empty_read_ignored", 32'(v), 0);

        // ---- back-pressure ----
        do_reset();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            do_event(AW'(32'h100 + i), 1'b0, 1'b0, lat, gap);
            if (lat != ACK_LAT || gap != FALL_LAT) bad++;
        end
        check("bp_handshakes", bad, 0);
        check("bp_full", 32'(FIFO_FULL), 1);
        AEROUT_ADDR = 12'h110;
        AEROUT_REQ  = 1'b1;
        repeat (20) tick();
        check("bp_ack_withheld", 32'(AEROUT_ACK), 0);
        check("bp_still_full", 32'(FIFO_FULL), 1);
        pop_one(a, v);
        p = cyc;
        check("bp_pop_addr", 32'(a), 32'h100);
        check("bp_pop_valid", 32'(v), 1);
        wait_ack(1'b1, r);
        check("bp_accept_latency", r - p, 1 + 2 + AD);
        AEROUT_REQ = 1'b0;
        wait_ack(1'b0, f);
        check("bp_full_again", 32'(FIFO_FULL), 1);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            pop_one(a, v);
            if (v !== 1'b1 || a !== AW'(32'h101 + i)) bad++;
        end
        check("bp_drain_order", bad, 0);
        check("bp_drained_empty", 32'(FIFO_EMPTY), 1);

        // ---- ordering and pointer wrap, with push and pop in the same cycle ----
        do_reset();
        rd_q.delete();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            do_event(AW'(i), i >= 3, 1'b0, lat, gap);
            if (lat != ACK_LAT || gap != FALL_LAT) bad++;
        end
        check("order_handshakes", bad, 0);
        check("order_occupancy_kept", 32'(FIFO_EMPTY), 0);
        check("order_evt_saturated", 32'(EVT_COUNT), 15);
        RD_EN = 1'b1;
        repeat (6) tick();
        RD_EN = 1'b0;
        tick();
        check("order_count", rd_q.size(), 40);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= rd_q.size() || rd_q[i] !== AW'(i)) bad++;
        end
        check("order_sequence", bad, 0);

        // ---- sample boundary ----
        do_reset();
        for (int i = 0; i < 4; i++) do_event(AW'(32'h50 + i), 1'b0, 1'b0, lat, gap);
        do_event(12'h054, 1'b0, 1'b1, lat, gap);
        check("sd_evt_last", 32'(EVT_COUNT_LAST), 4);
        check("sd_evt_count", 32'(EVT_COUNT), 1);
        check("sd_handshake", lat, ACK_LAT);
        SAMPLE_DONE = 1'b1;
        tick();
        SAMPLE_DONE = 1'b0;
        check("sd_solo_last", 32'(EVT_COUNT_LAST), 1);
        check("sd_solo_count", 32'(EVT_COUNT), 0);
        check("sd_no_flush", 32'(FIFO_EMPTY), 0);

        // ---- saturation ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            do_event(AW'(i), 1'b0, 1'b0, lat, gap);
            pop_one(a, v);
            if (i == 13) check("sat_count_14", 32'(EVT_COUNT), 14);
        end
        check("sat_count_15", 32'(EVT_COUNT), 15);

        // ---- reset mid-operation ----
        do_reset();
        for (int i = 0; i < 3; i++) do_event(AW'(32'h30 + i), 1'b0, 1'b0, lat, gap);
        AEROUT_ADDR = 12'h03C;
        AEROUT_REQ  = 1'b1;
        repeat (2 + SYNC_LAT) tick();
        RST = 1'b1;
        #1;
        check("midrst_ack", 32'(AEROUT_ACK), 0);
        check("midrst_empty", 32'(FIFO_EMPTY), 1);
        check("midrst_evt_count", 32'(EVT_COUNT), 0);
        check("midrst_full", 32'(FIFO_FULL), 0);
        tick();
        RST = 1'b0;
        e = cyc;
        wait_ack(1'b1, r);
        check("midrst_new_capture_latency", r - (e + 1), ACK_LAT);
        RST = 1'b1;
        #1;
        check("midrst_ack_drops_now", 32'(AEROUT_ACK), 0);
        RST = 1'b0;
        e = cyc;
        wait_ack(1'b1, r);
        check("postrst_recapture_latency", r - (e + 1), ACK_LAT);
        AEROUT_REQ = 1'b0;
        wait_ack(1'b0, f);
        check("postrst_evt_count", 32'(EVT_COUNT), 1);
        check("postrst_not_empty", 32'(FIFO_EMPTY), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
